// File: rtl/coef_load_ctrl_pkg.sv
// coef_load_ctrl_pkg
//   Shared definitions for the coefficient-reload controller and the blocks
//   around it: FSM state encoding, default coefficient widths and a small
//   helper used to size counters.
package coef_load_ctrl_pkg;

   localparam int CW_DEF = 19;   // coefficient word width (CIN)
   localparam int AW_DEF = 11;   // coefficient address width (CADDR)

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_LOAD   = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/coef_load_ctrl_addr_gen.sv
// coef_addr_gen
//   Latches base/count at reload start and walks the coefficient index.
//   Ports:
//     clk, resetn      clock, async active-low reset
//     load             capture base/count and clear the index
//     base, count      reload window (sampled on load)
//     inc              advance index (one accepted beat)
//     addr             (base + idx) mod 2^AW
//     last             idx == count-1, i.e. the current beat ends the burst
module coef_addr_gen #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          load,
   input  logic [AW-1:0] base,
   input  logic [AW:0]   count,
   input  logic          inc,
   output logic [AW-1:0] addr,
   output logic          last
);

   logic [AW-1:0] base_q;
   logic [AW:0]   count_q;
   logic [AW:0]   idx;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         base_q  <= '0;
         count_q <= '0;
         idx     <= '0;
      end else if (load) begin
         base_q  <= base;
         count_q <= count;
         idx     <= '0;
      end else if (inc) begin
         idx <= idx + 1'b1;
      end
   end

   // Truncating add gives the modulo-2^AW wrap for free.
   assign addr = base_q + idx[AW-1:0];
   assign last = (idx == count_q - 1'b1);

endmodule

// File: rtl/coef_load_ctrl.sv
// coef_load_ctrl
//   Sequences a run-time reload of the fir_filter coefficient memory:
//   IDLE -> DRAIN (hold filter, let in-flight samples drain) -> LOAD (accept
//   coefficient beats, write CIN/CADDR/CLOAD) -> SETTLE (hold) -> IDLE.
//   Ports:
//     clk, resetn                 clock, async active-low reset
//     cfg_start/base/count        start pulse and reload window
//     cfg_abort                   cut a reload short (goes to SETTLE)
//     err_clr                     clear sticky err
//     s_valid/s_data/s_ready      coefficient stream
//     CIN/CADDR/CLOAD             coefficient write port to fir_filter
//     filt_hold                   quiet the filter datapath
//     busy/done/err               status
//   Every output is a flop; the output values are computed from the
//   next state so registered outputs line up with the state they describe.
module coef_load_ctrl
   import coef_load_ctrl_pkg::*;
#(
   parameter int CW            = CW_DEF,
   parameter int AW            = AW_DEF,
   parameter int NUM_ENTRIES   = 2048,
   parameter int DRAIN_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          cfg_start,
   input  logic [AW-1:0] cfg_base,
   input  logic [AW:0]   cfg_count,
   input  logic          cfg_abort,
   input  logic          err_clr,
   input  logic          s_valid,
   input  logic [CW-1:0] s_data,
   output logic          s_ready,
   output logic [CW-1:0] CIN,
   output logic [AW-1:0] CADDR,
   output logic          CLOAD,
   output logic          filt_hold,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int               CNT_W     = $clog2(max_int(DRAIN_CYCLES, SETTLE_CYCLES) + 1);
   localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [AW:0]      MAX_CNT   = (AW+1)'(NUM_ENTRIES);

   state_t           state, nx_state;
   logic [CNT_W-1:0] cnt, nx_cnt;
   logic             beat, start_ok, abort_hit, err_set;
   logic             nx_busy, nx_ready, nx_done, nx_err;
   logic [AW-1:0]    gen_addr;
   logic             gen_last;

   // s_ready is a flop that is high exactly while in LOAD.
   assign beat      = s_ready & s_valid;
   assign start_ok  = cfg_start && (state == ST_IDLE) &&
                      (cfg_count != '0) && (cfg_count <= MAX_CNT);
   assign abort_hit = cfg_abort && ((state == ST_DRAIN) || (state == ST_LOAD));
   // A start that is not taken is either an illegal count or a start while busy.
   assign err_set   = (cfg_start && !start_ok) || abort_hit;

   coef_addr_gen #(.AW(AW)) u_addr_gen (
      .clk    (clk),
      .resetn (resetn),
      .load   (start_ok),
      .base   (cfg_base),
      .count  (cfg_count),
      .inc    (beat),
      .addr   (gen_addr),
      .last   (gen_last)
   );

   // State and phase down-counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= nx_state;
         cnt   <= nx_cnt;
      end
   end

   // Next state.
   always_comb begin
      nx_state = state;
      nx_cnt   = cnt;
      unique case (state)
         ST_IDLE: begin
            if (start_ok) begin
               nx_state = ST_DRAIN;
               nx_cnt   = DRAIN_LD;
            end
         end
         ST_DRAIN: begin
            if (abort_hit) begin
               nx_state = ST_SETTLE;
               nx_cnt   = SETTLE_LD;
            end else if (cnt == '0) begin
               nx_state = ST_LOAD;
            end else begin
               nx_cnt = cnt - 1'b1;
            end
         end
         ST_LOAD: begin
            // A beat taken alongside abort is still written by the output regs.
            if (abort_hit || (beat && gen_last)) begin
               nx_state = ST_SETTLE;
               nx_cnt   = SETTLE_LD;
            end
         end
         ST_SETTLE: begin
            if (cnt == '0) nx_state = ST_IDLE;
            else           nx_cnt   = cnt - 1'b1;
         end
         default: nx_state = ST_IDLE;
      endcase
   end

   // Next output values.
   always_comb begin
      nx_busy  = (nx_state != ST_IDLE);
      nx_ready = (nx_state == ST_LOAD);
      nx_done  = (state == ST_SETTLE) && (nx_state == ST_IDLE);
      nx_err   = err_set || (err && !err_clr);   // set beats clear
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_ready   <= 1'b0;
         CIN       <= '0;
         CADDR     <= '0;
         CLOAD     <= 1'b0;
         filt_hold <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         s_ready   <= nx_ready;
         CLOAD     <= beat;
         if (beat) begin
            CIN   <= s_data;
            CADDR <= gen_addr;
         end
         // Hold spans DRAIN, LOAD and SETTLE, i.e. every busy cycle.
         filt_hold <= nx_busy;
         busy      <= nx_busy;
         done      <= nx_done;
         err       <= nx_err;
      end
   end

endmodule

// File: tb/tb_coef_load_ctrl.sv
module tb_coef_load_ctrl;
   localparam int CW = 19;
   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          cfg_start = 1'b0;
   logic [AW-1:0] cfg_base = '0;
   logic [AW:0]   cfg_count = '0;
   logic          cfg_abort = 1'b0;
   logic          err_clr = 1'b0;
   logic          s_valid = 1'b0;
   logic [CW-1:0] s_data = '0;
   logic          s_ready;
   logic [CW-1:0] CIN;
   logic [AW-1:0] CADDR;
   logic          CLOAD, filt_hold, busy, done, err;

   coef_load_ctrl dut (
      .clk(clk), .resetn(resetn), .cfg_start(cfg_start), .cfg_base(cfg_base),
      .cfg_count(cfg_count), .cfg_abort(cfg_abort), .err_clr(err_clr),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .CIN(CIN),
      .CADDR(CADDR), .CLOAD(CLOAD), .filt_hold(filt_hold), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc;
   int wr_addr[$];
   int wr_data[$];
   int wr_cyc[$];
   int consec, rdy_cnt, hold_gap;
   logic prev_cload;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle and log what the write port shows.
   task automatic step();
      @(posedge clk); #1;
      cyc++;
      if (CLOAD) begin
         wr_addr.push_back(int'(CADDR));
         wr_data.push_back(int'(CIN));
         wr_cyc.push_back(cyc);
         if (prev_cload) consec++;
      end
      prev_cload = CLOAD;
      if (s_ready) rdy_cnt++;
   endtask

   // One reload. Data beats are 0x100, 0x101, ...; cycle 0 is the start cycle.
   task automatic run(input int base, input int count, input bit toggle,
                      input int busy_at, input int abort_at, output int done_cyc);
      int beats;
      bit beat, busy_sent, abort_sent;
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      consec = 0; rdy_cnt = 0; hold_gap = 0; prev_cload = 1'b0;
      cyc = 0; beats = 0; done_cyc = -1; busy_sent = 0; abort_sent = 0;
      cfg_base = AW'(base); cfg_count = (AW+1)'(count); cfg_start = 1'b1;
      s_valid = 1'b1; s_data = CW'(32'h100);
      step();
      cfg_start = 1'b0;
      chk("busy_c1", 32'(busy), 32'd1);
      chk("hold_c1", 32'(filt_hold), 32'd1);
      chk("rdy_c1", 32'(s_ready), 32'd0);
      while (cyc < 4000) begin
         if (done) begin
            done_cyc = cyc;
            chk("hold_at_done", 32'(filt_hold), 32'd0);
            chk("busy_at_done", 32'(busy), 32'd0);
            break;
         end
         if (!filt_hold) hold_gap++;
         cfg_start = 1'b0; cfg_abort = 1'b0; err_clr = 1'b0;
         if (toggle) s_valid = ~s_valid;
         if (busy_at >= 0 && beats == busy_at && !busy_sent && s_ready) begin
            cfg_start = 1'b1; cfg_base = AW'(12'h700); cfg_count = (AW+1)'(2);
            busy_sent = 1;
         end
         if (abort_at >= 0 && beats == abort_at && !abort_sent && s_ready) begin
            cfg_abort = 1'b1; err_clr = 1'b1; s_valid = 1'b0;
            abort_sent = 1;
         end
         beat = s_valid && s_ready;
         step();
         if (beat) begin
            beats++;
            s_data = CW'(32'h100 + beats);
         end
      end
      cfg_start = 1'b0; cfg_abort = 1'b0; err_clr = 1'b0; s_valid = 1'b0;
      if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic chk_writes(input string tag, input int base, input int n);
      chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'((base + i) % 2048));
         chk($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'h100 + 32'(i));
      end
   endtask

   initial begin
      int dc, bad;
      cyc = 0; prev_cload = 1'b0;
      #12;
      chk("rst_outs", 32'({s_ready, CLOAD, filt_hold, busy, done, err}), 32'd0);
      chk("rst_cin", 32'(CIN), 32'd0);
      chk("rst_caddr", 32'(CADDR), 32'd0);
      resetn = 1'b1;
      step();

      // Normal load: base 0, count 8, continuous beats.
      run(0, 8, 0, -1, -1, dc);
      chk("n_done_cyc", 32'(dc), 32'd17);
      chk_writes("n", 0, 8);
      if (wr_cyc.size() == 8) begin
         chk("n_first_cload", 32'(wr_cyc[0]), 32'd6);
         chk("n_last_cload", 32'(wr_cyc[7]), 32'd13);
      end
      chk("n_consec", 32'(consec), 32'd7);
      chk("n_rdy_cycles", 32'(rdy_cnt), 32'd8);
      chk("n_hold_gap", 32'(hold_gap), 32'd0);
      chk("n_err", 32'(err), 32'd0);

      // Wrap with stalls: beats on alternate cycles.
      run(2046, 4, 1, -1, -1, dc);
      chk("w_done_cyc", 32'(dc), 32'd17);
      chk_writes("w", 2046, 4);
      chk("w_consec", 32'(consec), 32'd0);
      chk("w_rdy_cycles", 32'(rdy_cnt), 32'd8);

      // Single entry at the top address.
      run(2047, 1, 0, -1, -1, dc);
      chk("one_done_cyc", 32'(dc), 32'd10);
      chk_writes("one", 2047, 1);

      // Illegal counts, error clear, set-wins, abort ignored in IDLE.
      cyc = 0;
      cfg_count = '0; cfg_start = 1'b1; step(); cfg_start = 1'b0;
      chk("ill0_err", 32'(err), 32'd1);
      chk("ill0_busy", 32'(busy), 32'd0);
      chk("ill0_cload", 32'(CLOAD), 32'd0);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("clr_err", 32'(err), 32'd0);
      cfg_count = (AW+1)'(2049); cfg_start = 1'b1; step(); cfg_start = 1'b0;
      chk("ill2049_err", 32'(err), 32'd1);
      step();
      chk("ill2049_busy", 32'(busy), 32'd0);
      chk("ill2049_hold", 32'(filt_hold), 32'd0);
      cfg_count = '0; cfg_start = 1'b1; err_clr = 1'b1; step();
      cfg_start = 1'b0; err_clr = 1'b0;
      chk("set_wins_idle", 32'(err), 32'd1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      cfg_abort = 1'b1; step(); cfg_abort = 1'b0;
      chk("abort_idle_err", 32'(err), 32'd0);
      chk("abort_idle_busy", 32'(busy), 32'd0);

      // Start while busy after beat 1, abort (with err_clr) after beat 3.
      run(16, 8, 0, 1, 3, dc);
      chk("a_done_cyc", 32'(dc), 32'd13);
      chk_writes("a", 16, 3);
      chk("a_rdy_cycles", 32'(rdy_cnt), 32'd4);
      chk("a_hold_gap", 32'(hold_gap), 32'd0);
      chk("a_err", 32'(err), 32'd1);
      err_clr = 1'b1; step(); err_clr = 1'b0;

      // Reset asynchronously mid-LOAD.
      cyc = 0; cfg_base = AW'(5); cfg_count = (AW+1)'(8);
      cfg_start = 1'b1; s_valid = 1'b1; step(); cfg_start = 1'b0;
      repeat (6) step();
      chk("pre_rst_cload", 32'(CLOAD), 32'd1);
      #3 resetn = 1'b0;
      #1;
      chk("mid_rst_outs", 32'({s_ready, CLOAD, filt_hold, busy, done, err}), 32'd0);
      chk("mid_rst_caddr", 32'(CADDR), 32'd0);
      chk("mid_rst_cin", 32'(CIN), 32'd0);
      s_valid = 1'b0;
      @(posedge clk); #2 resetn = 1'b1;
      step();

      // Full-size reload sweeping every address.
      run(0, 2048, 0, -1, -1, dc);
      chk("full_done_cyc", 32'(dc), 32'd2057);
      chk("full_nwr", 32'(wr_addr.size()), 32'd2048);
      bad = 0;
      for (int i = 0; i < wr_addr.size(); i++)
         if (wr_addr[i] != i || wr_data[i] != ((32'h100 + i) & 32'h7FFFF)) bad++;
      chk("full_sweep_bad", 32'(bad), 32'd0);
      chk("full_consec", 32'(consec), 32'd2047);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
